// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides.
// Occupancy alone decides full/empty; pointers wrap by natural overflow.
module stream_fifo #(
  parameter int BITS  = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [BITS-1:0]          s_data_in,
  input  logic                     s_valid_in,
  output logic                     s_ready_out,
  output logic [BITS-1:0]          m_data_out,
  output logic                     m_valid_out,
  input  logic                     m_ready_in,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     full_out,
  output logic                     empty_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_live;

  logic            w_push;
  logic            w_pop;

  assign s_ready_out = r_live & (r_count != FULL_CNT);
  assign m_valid_out = (r_count != '0);
  assign m_data_out  = m_valid_out ? r_mem[r_rd_ptr] : '0;
  assign count_out   = r_count;
  assign full_out    = (r_count == FULL_CNT);
  assign empty_out   = (r_count == '0);

  assign w_push = s_valid_in & s_ready_out;
  assign w_pop  = m_valid_out & m_ready_in;

  // Storage is deliberately left out of reset; only pointers and count are cleared.
  always_ff @(posedge clk_in) begin
    if (rst_in && w_push) begin
      r_mem[r_wr_ptr] <= s_data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
